// File: rtl/bus_pkg.sv
// bus_pkg: bus-cycle states, bus widths and request record shared by initiator and responder
package bus_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {S_TI, S_T1, S_T2, S_T3, S_T4, S_TW} bus_state_e;
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              iom;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/bus_initiator_if.sv
// bus_initiator_if: request handshake and bus control pins; master = initiator, slave = requester/responder view
interface bus_initiator_if;
  import bus_pkg::*;
  logic              REQ;
  logic              REQ_WR;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              REQ_IOM;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              ACK;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
  logic              CS;
  logic              ALE;
  logic [ADDR_W-1:0] Address;
  logic              IOM;
  logic              RD;
  logic              WR;
  modport master (
    input  REQ, REQ_WR, REQ_ADDR, REQ_IOM, REQ_WDATA,
    output ACK, RDATA, BUSY, CS, ALE, Address, IOM, RD, WR
  );
  modport slave (
    output REQ, REQ_WR, REQ_ADDR, REQ_IOM, REQ_WDATA,
    input  ACK, RDATA, BUSY, CS, ALE, Address, IOM, RD, WR
  );
endinterface

// File: rtl/bus_initiator.sv
// bus_initiator: TI/T1..T4 bus-cycle initiator with TI_GAP idle spacing; define READY_EN for READY input and TW wait states
module bus_initiator
  import bus_pkg::*;
#(
  parameter int TI_GAP = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
`ifdef READY_EN
  input  logic                    READY,
`endif
  bus_initiator_if.master         bus,
  inout  wire  [DATA_W-1:0]       Data
);
  localparam int GAP_W = (TI_GAP > 0) ? $clog2(TI_GAP + 1) : 1;
  bus_state_e        r_state;
  bus_req_t          r_req;
  logic [GAP_W-1:0]  r_gap;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_cs;
  logic              r_ale;
  logic              r_rd;
  logic              r_wr;
  logic              r_oe;
  logic              w_go;
`ifdef READY_EN
  assign w_go = READY;
`else
  assign w_go = 1'b1;
`endif
  // Every output is a registered function of the state transition, never of REQ directly
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_TI;
      r_req   <= '0;
      r_gap   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_ale   <= 1'b0;
      r_rd    <= 1'b1;
      r_wr    <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_TI: begin
          if (|r_gap) r_gap <= r_gap - GAP_W'(1);
          else if (bus.REQ) begin
            r_req   <= '{wr: bus.REQ_WR, addr: bus.REQ_ADDR, iom: bus.REQ_IOM, wdata: bus.REQ_WDATA};
            r_state <= S_T1;
            r_busy  <= 1'b1;
            r_cs    <= 1'b1;
            r_ale   <= 1'b1;
          end
        end
        S_T1: begin
          r_state <= S_T2;
          r_ale   <= 1'b0;
          r_rd    <= r_req.wr;
          r_wr    <= !r_req.wr;
          r_oe    <= r_req.wr;
        end
        S_T2: r_state <= S_T3;
        S_T3, S_TW: begin
          if (w_go) begin
            r_state <= S_T4;
            r_rd    <= 1'b1;
            r_wr    <= 1'b1;
            r_oe    <= 1'b0;
            r_ack   <= 1'b1;
            if (!r_req.wr) r_rdata <= Data;
          end else r_state <= S_TW;
        end
        S_T4: begin
          r_state <= S_TI;
          r_busy  <= 1'b0;
          r_cs    <= 1'b0;
          r_gap   <= GAP_W'(TI_GAP);
        end
        default: r_state <= S_TI;
      endcase
    end
  end
  assign Data        = r_oe ? r_req.wdata : {DATA_W{1'bz}};
  assign bus.ACK     = r_ack;
  assign bus.RDATA   = r_rdata;
  assign bus.BUSY    = r_busy;
  assign bus.CS      = r_cs;
  assign bus.ALE     = r_ale;
  assign bus.Address = r_req.addr;
  assign bus.IOM     = r_req.iom;
  assign bus.RD      = r_rd;
  assign bus.WR      = r_wr;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed and random bus cycles against a memory responder and a transaction-level reference model
module tb_bus_initiator;
  import bus_pkg::*;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic READY = 1'b1;
  logic ready2 = 1'b1;
  always #5 CLK = ~CLK;
  bus_initiator_if bif();
  bus_initiator_if bif2();
  wire [7:0] Data;
  wire [7:0] Data2;
  bus_initiator #(.TI_GAP(0)) dut (
    .CLK(CLK), .RESET(RESET),
`ifdef READY_EN
    .READY(READY),
`endif
    .bus(bif), .Data(Data)
  );
  bus_initiator #(.TI_GAP(2)) dut2 (
    .CLK(CLK), .RESET(RESET),
`ifdef READY_EN
    .READY(ready2),
`endif
    .bus(bif2), .Data(Data2)
  );
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  logic [7:0]  mem [0:(1<<20)-1];
  logic        pre_en = 1'b0;
  logic [19:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic        pend = 1'b0;
  logic [19:0] paddr = '0;
  logic [7:0]  pdata = '0;
  // Responder qualified on IOM=1: drives reads while RD low, commits writes when WR rises inside the cycle
  assign Data  = (bif.CS && !bif.RD && bif.IOM) ? mem[bif.Address] : 8'hzz;
  assign Data2 = (bif2.CS && !bif2.RD) ? 8'h77 : 8'hzz;
  always @(posedge CLK) begin
    if (bif.CS && !bif.WR && bif.IOM) begin
      pend  <= 1'b1;
      paddr <= bif.Address;
      pdata <= Data;
    end else begin
      pend <= 1'b0;
      if (pend && bif.CS) mem[paddr] <= pdata;
    end
    if (pre_en) mem[pre_addr] <= pre_data;
  end
  logic [7:0]  ref_mem [logic [19:0]];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          in_t4 = 1'b0;
  int          last_ack = 0;
  logic [19:0] last_addr = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_ack", bif.ACK, 0);
    chk("rst_rdata", bif.RDATA, 0);
    chk("rst_busy", bif.BUSY, 0);
    chk("rst_cs", bif.CS, 0);
    chk("rst_ale", bif.ALE, 0);
    chk("rst_addr", bif.Address, 0);
    chk("rst_iom", bif.IOM, 0);
    chk("rst_rd", bif.RD, 1);
    chk("rst_wr", bif.WR, 1);
  endtask
  task automatic preload(input logic [19:0] a, input logic [7:0] d);
    pre_en = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge CLK);
    pre_en = 1'b0;
    ref_mem[a] = d;
    in_t4 = 1'b0;
  endtask
  // Called at a negedge; if the previous call ended in T4 the request waits one TI cycle
  task automatic xfer(input logic wr, input logic [19:0] a, input logic iom, input logic [7:0] wd, input int nw);
    int off;
    logic [7:0] exp_rd;
    off = in_t4 ? 1 : 0;
    exp_rd = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    bif.REQ = 1'b1;
    bif.REQ_WR = wr;
    bif.REQ_ADDR = a;
    bif.REQ_IOM = iom;
    bif.REQ_WDATA = wd;
    READY = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int s;
      @(posedge CLK);
      @(negedge CLK);
      s = k - off;
      if (s <= 0) begin
        chk("ti_busy", bif.BUSY, 0);
        chk("ti_cs", bif.CS, 0);
        chk("ti_ack", bif.ACK, 0);
        chk("ti_addr_hold", bif.Address, last_addr);
      end else begin
        chk("busy", bif.BUSY, 1);
        chk("cs", bif.CS, 1);
        chk("addr", bif.Address, a);
        chk("iom", bif.IOM, iom);
        chk("ale", bif.ALE, 32'(s == 1));
        chk("rd", bif.RD, 32'(!(!wr && s >= 2 && s < 4 + nw)));
        chk("wr", bif.WR, 32'(!(wr && s >= 2 && s < 4 + nw)));
        if (wr && s >= 2 && s < 4 + nw) chk("wdata", Data, wd);
        chk("ack", bif.ACK, 32'(s == 4 + nw));
        if (s == 4 + nw) begin
          if (!wr) chk("rdata", bif.RDATA, exp_rd);
          if (off == 1) chk("ack_spacing", cyc - last_ack, 5 + nw);
          last_ack = cyc;
          break;
        end
      end
      READY = (s >= 3 + nw);
    end
    bif.REQ = 1'b0;
    READY = 1'b1;
    in_t4 = 1'b1;
    last_addr = a;
    if (wr && iom) ref_mem[a] = wd;
  endtask
  initial begin
    int t1, t2, nw;
    logic rw, riom;
    logic [19:0] ra;
    logic [7:0] rd8;
    bif.REQ = 0; bif.REQ_WR = 0; bif.REQ_ADDR = '0; bif.REQ_IOM = 0; bif.REQ_WDATA = '0;
    bif2.REQ = 0; bif2.REQ_WR = 0; bif2.REQ_ADDR = 20'h00055; bif2.REQ_IOM = 1; bif2.REQ_WDATA = '0;
    repeat (3) @(negedge CLK);
    chk_reset();
    RESET = 1'b0;
    preload(20'h12345, 8'hA5);
    xfer(0, 20'h12345, 1, 8'h00, 0);
    xfer(1, 20'h00010, 1, 8'h3C, 0);
    xfer(0, 20'h00010, 1, 8'h00, 0);
    xfer(0, 20'h12345, 1, 8'h00, 0);
    preload(20'h00030, 8'h66);
    xfer(1, 20'h00030, 0, 8'h55, 0);
    xfer(0, 20'h00030, 1, 8'h00, 0);
`ifdef READY_EN
    preload(20'h0ABCD, 8'h5A);
    xfer(0, 20'h0ABCD, 1, 8'h00, 2);
`endif
    preload(20'h00020, 8'h11);
    bif.REQ = 1; bif.REQ_WR = 1; bif.REQ_ADDR = 20'h00020; bif.REQ_IOM = 1; bif.REQ_WDATA = 8'h99;
    @(posedge CLK);
    repeat (3) @(negedge CLK);
    chk("abort_in_t3_wr", bif.WR, 0);
    RESET = 1'b1;
    bif.REQ = 0;
    @(negedge CLK);
    chk_reset();
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_no_ack", bif.ACK, 0);
    in_t4 = 1'b0;
    last_addr = '0;
    xfer(0, 20'h00020, 1, 8'h00, 0);
    for (int i = 0; i < 8; i++) preload(20'h00100 + 20'(i), 8'($urandom));
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 20'h00100 + 20'($urandom_range(0, 7));
      riom = rw ? 1'($urandom_range(0, 1)) : 1'b1;
      rd8 = 8'($urandom);
`ifdef READY_EN
      nw = int'($urandom_range(0, 2));
`else
      nw = 0;
`endif
      xfer(rw, ra, riom, rd8, nw);
    end
    t1 = -1;
    t2 = -1;
    bif2.REQ = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bif2.ACK) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("gap2_rdata", bif2.RDATA, 8'h77);
        end else if (t2 < 0) t2 = cyc;
      end
    end
    bif2.REQ = 1'b0;
    chk("gap2_spacing", t2 - t1, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
